// File: rtl/seq_bypass_divider.sv
// Sequential radix-2 restoring unsigned divider with leading-zero bypass.
// One quotient bit per cycle, starting at the dividend's most significant set bit.
module seq_bypass_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [IW-1:0]    idx_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;
    logic [IW-1:0]    msb_idx;
    logic             accept;
    logic             dvd_zero;
    logic             dvs_zero;
    logic             cur_bit;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign accept   = in_valid && (state_reg == IDLE);
    assign dvd_zero = (dividend == '0);
    assign dvs_zero = (divisor == '0);

    // Position of the highest set dividend bit; iterations above it are skipped.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dividend[i]) begin
                msb_idx = IW'(i);
            end
        end
    end

    // Trial subtraction inputs are forced to zero outside ITER so the
    // comparator and subtractor stay quiet while idle or holding a result.
    assign cur_bit = dvd_reg[idx_reg];
    assign trial   = (state_reg == ITER) ? {rem_reg, cur_bit} : '0;
    assign ge      = (trial >= {1'b0, dvs_reg});
    assign diff    = trial[WIDTH-1:0] - dvs_reg;

    always_comb begin
        quo_next          = quo_reg;
        quo_next[idx_reg] = ge;
        rem_next          = ge ? diff : trial[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (dvs_zero || dvd_zero) ? DONE : ITER;
                end
            end
            ITER: begin
                if (idx_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend on state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, special-case results and the iteration step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_reg <= '0;
            dvs_reg <= '0;
            quo_reg <= '0;
            rem_reg <= '0;
            idx_reg <= '0;
            dbz_reg <= 1'b0;
        end else if (accept) begin
            dbz_reg <= dvs_zero;
            if (dvs_zero) begin
                quo_reg <= '1;
                rem_reg <= dividend;
            end else if (dvd_zero) begin
                quo_reg <= '0;
                rem_reg <= '0;
            end else begin
                quo_reg <= '0;
                rem_reg <= '0;
                dvd_reg <= dividend;
                dvs_reg <= divisor;
                idx_reg <= msb_idx;
            end
        end else if (state_reg == ITER) begin
            quo_reg <= quo_next;
            rem_reg <= rem_next;
            idx_reg <= idx_reg - 1'b1;
        end
    end

    assign quotient    = quo_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dbz_reg;

endmodule
